eth_udp_tx_payload_buf: RTL

ETH_UDP_TX_PAYLOAD_BUF -- requirements
Module: eth_udp_tx_payload_buf

---
 rtl/eth_udp_pkg.sv | 15 +
 rtl/eth_udp_tx_payload_buf_if.sv | 25 ++
 rtl/payload_sdp_ram.sv | 20 ++
 rtl/eth_udp_tx_payload_buf.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/eth_udp_pkg.sv
// rtl/eth_udp_pkg.sv - shared state encodings and limits for the UDP TX payload buffer
package eth_udp_pkg;

  localparam int MAX_LEN_DEFAULT = 1472;
  localparam int SETUP_CYCLES    = 3;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_SETUP     = 5'b00010,
    ST_START     = 5'b00100,
    ST_SEND      = 5'b01000,
    ST_WAIT_DONE = 5'b10000
  } tx_state_t;

endpackage

// File: rtl/eth_udp_tx_payload_buf_if.sv
// rtl/eth_udp_tx_payload_buf_if.sv - user write side and UDP transmitter side of the payload buffer
interface eth_udp_tx_payload_buf_if;

  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        tx_en_pulse;
  logic [15:0] data_length;
  logic        tx_done;
  logic        payload_req;
  logic [7:0]  payload_dat;
  logic        underrun;

  modport master (
    output wr_en, wr_data, wr_last, tx_done, payload_req,
    input  wr_ready, tx_en_pulse, data_length, payload_dat, underrun
  );

  modport slave (
    input  wr_en, wr_data, wr_last, tx_done, payload_req,
    output wr_ready, tx_en_pulse, data_length, payload_dat, underrun
  );

endinterface

// File: rtl/payload_sdp_ram.sv
// rtl/payload_sdp_ram.sv - simple dual-port byte RAM with one-cycle registered read
module payload_sdp_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_udp_tx_payload_buf.sv
// rtl/eth_udp_tx_payload_buf.sv - packet-committing payload buffer feeding a UDP transmitter
// PAYLOAD_BUF_STATS_EN adds pkt_sent_cnt / pkt_drop_cnt outputs.
module eth_udp_tx_payload_buf
  import eth_udp_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int LEN_FIFO_AW = 4,
  parameter int MAX_LEN     = MAX_LEN_DEFAULT
) (
  input  logic clk125m,
  input  logic reset_p,
`ifdef PAYLOAD_BUF_STATS_EN
  eth_udp_tx_payload_buf_if.slave bus,
  output logic [31:0] pkt_sent_cnt,
  output logic [15:0] pkt_drop_cnt
`else
  eth_udp_tx_payload_buf_if.slave bus
`endif
);

  localparam int DEPTH    = 2**ADDR_W;
  localparam int LF_DEPTH = 2**LEN_FIFO_AW;

  typedef logic [ADDR_W:0] ptr_t;

  ptr_t                 wptr, cptr, rptr, rptr_nxt, free;
  logic [15:0]          pkt_len, sent_cnt, sent_nxt;
  logic                 discard;
  logic [15:0]          lf_mem [LF_DEPTH];
  logic [LEN_FIFO_AW:0] lf_wptr, lf_rptr;
  logic [1:0]           setup_cnt;
  logic                 zero_out;
  logic [7:0]           ram_q;
  tx_state_t            state;

  logic ram_full, lf_full, lf_empty, avail, consume;
  logic byte_in, too_long, drop, store, commit;

  assign ram_full = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign free     = ptr_t'(DEPTH) - (wptr - rptr);
  assign lf_full  = (lf_wptr[LEN_FIFO_AW] != lf_rptr[LEN_FIFO_AW]) &&
                    (lf_wptr[LEN_FIFO_AW-1:0] == lf_rptr[LEN_FIFO_AW-1:0]);
  assign lf_empty = (lf_wptr == lf_rptr);

  // Once a packet is dropped its remaining bytes are swallowed until wr_last.
  assign byte_in  = bus.wr_en && !discard;
  assign too_long = int'(pkt_len) >= MAX_LEN;
  assign drop     = byte_in && (ram_full || too_long || (bus.wr_last && lf_full));
  assign store    = byte_in && !drop;
  assign commit   = store && bus.wr_last;

  assign avail    = (cptr != rptr);
  assign consume  = bus.payload_req && avail;
  assign rptr_nxt = consume ? rptr + ptr_t'(1) : rptr;
  assign sent_nxt = sent_cnt + {15'd0, consume};

  // Reading at the next pointer keeps the current byte on ram_q (first-word-fall-through).
  payload_sdp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk125m),
    .wr_en   (store),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_data (bus.wr_data),
    .rd_addr (rptr_nxt[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  assign bus.payload_dat = zero_out ? 8'h00 : ram_q;

  always_ff @(posedge clk125m) begin
    if (commit) lf_mem[lf_wptr[LEN_FIFO_AW-1:0]] <= pkt_len + 16'd1;
  end

  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      wptr         <= '0;
      cptr         <= '0;
      pkt_len      <= '0;
      discard      <= 1'b0;
      lf_wptr      <= '0;
      bus.wr_ready <= 1'b0;
    end else begin
      bus.wr_ready <= (int'(free) >= MAX_LEN) && !lf_full;
      if (drop) begin
        wptr    <= cptr;
        pkt_len <= '0;
        discard <= !bus.wr_last;
      end else if (store) begin
        wptr <= wptr + ptr_t'(1);
        if (bus.wr_last) begin
          cptr    <= wptr + ptr_t'(1);
          pkt_len <= '0;
          lf_wptr <= lf_wptr + 1'b1;
        end else begin
          pkt_len <= pkt_len + 16'd1;
        end
      end else if (bus.wr_en && bus.wr_last) begin
        discard <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      state           <= ST_IDLE;
      setup_cnt       <= '0;
      sent_cnt        <= '0;
      rptr            <= '0;
      lf_rptr         <= '0;
      zero_out        <= 1'b1;
      bus.underrun    <= 1'b0;
      bus.tx_en_pulse <= 1'b0;
      bus.data_length <= '0;
    end else begin
      rptr            <= rptr_nxt;
      sent_cnt        <= sent_nxt;
      zero_out        <= bus.payload_req && !avail;
      bus.tx_en_pulse <= 1'b0;
      if (bus.payload_req && !avail) bus.underrun <= 1'b1;
      case (state)
        ST_IDLE: if (!lf_empty) begin
          state           <= ST_SETUP;
          bus.data_length <= lf_mem[lf_rptr[LEN_FIFO_AW-1:0]];
          lf_rptr         <= lf_rptr + 1'b1;
          setup_cnt       <= '0;
          sent_cnt        <= '0;
        end
        // Length must settle in the transmitter's IP header pipeline before the start pulse.
        ST_SETUP: if (setup_cnt == 2'(SETUP_CYCLES - 1)) begin
          state           <= ST_START;
          bus.tx_en_pulse <= 1'b1;
        end else begin
          setup_cnt <= setup_cnt + 1'b1;
        end
        ST_START:     state <= ST_SEND;
        ST_SEND:      if (sent_nxt >= bus.data_length) state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (bus.tx_done) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

`ifdef PAYLOAD_BUF_STATS_EN
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      pkt_sent_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (state == ST_WAIT_DONE && bus.tx_done) pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
      if (drop && pkt_drop_cnt != 16'hFFFF) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
    end
  end
`endif

endmodule
